regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the address width; depth = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_R0, default 0; when 1, entry 0 reads as zero and ignores writes.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have port wrt, input, 1, the write enable.
REQ-007 The block SHALL have port Rd, input, ADDR_W, the write address.
REQ-008 The block SHALL have ports Rs and Rt, input, ADDR_W each, the read addresses.
REQ-009 The block SHALL have port data_in, input, DATA_W, the write data.
REQ-010 The block SHALL have port clr, input, 1, a synchronous request to clear all entries.
REQ-011 The block SHALL have ports Rs_out and Rt_out, output, DATA_W each, the registered read data.
REQ-012 The block SHALL have port busy, output, 1, high while a clear sweep is in progress.

Function
REQ-013 The block SHALL hold 2**ADDR_W entries of DATA_W bits each.
REQ-014 The block SHALL run a state machine with states IDLE and CLEAR.
- IDLE -> CLEAR on rst assertion, or on clr=1 at a clock edge.
- CLEAR -> IDLE on the edge that writes the last entry.
REQ-015 In CLEAR, a counter SHALL start at 0, zero one entry per cycle in ascending order, and take exactly 2**ADDR_W cycles; busy=1 for exactly those cycles.
REQ-016 busy SHALL be registered; it SHALL read 1 from reset release, or from the edge after clr is sampled, until the edge that leaves CLEAR.
REQ-017 While busy=1, wrt SHALL be ignored, clr SHALL be ignored, and Rs_out and Rt_out SHALL be driven to 0.
REQ-018 In IDLE with wrt=1, data_in SHALL be written to entry Rd at the rising edge.
REQ-019 In IDLE, Rs_out and Rt_out SHALL be updated at each rising edge with the contents of entries Rs and Rt; read latency is one cycle.
REQ-020 When wrt=1 and Rd equals Rs (or Rt) in the same cycle, the matching output SHALL return data_in (write-first bypass).
REQ-021 When ZERO_R0=1, a read of address 0 SHALL return 0 regardless of bypass, and writes to address 0 SHALL have no effect.
REQ-022 When clr=1 and wrt=1 coincide in IDLE, the write SHALL NOT occur; clear takes priority.
REQ-023 Rs equal to Rt SHALL return identical data on both outputs.
REQ-024 There SHALL be no other storage side effects; entry contents hold indefinitely in IDLE when wrt=0.

Reset
REQ-025 Asserting rst at any time, including mid-sweep, SHALL immediately set Rs_out=0, Rt_out=0, busy=1, state=CLEAR and counter=0.
REQ-026 After rst deasserts, the sweep SHALL run the full 2**ADDR_W cycles from entry 0; a sweep interrupted by rst restarts from 0.
REQ-027 No entry SHALL read nonzero until busy has fallen after reset.

Verification
REQ-028 The bench SHALL cover the reset sweep with defaults: release rst, count cycles -> busy=1 for exactly 64 cycles, then read all 64 entries -> each reads 0x00000000.
REQ-029 The bench SHALL cover write then read: write 0xDEADBEEF to Rd=21, then next cycle Rs=21 -> Rs_out=0xDEADBEEF one cycle later.
REQ-030 The bench SHALL cover the bypass case: wrt=1, Rd=Rs=Rt=7, data_in=0x5 -> both outputs 0x5 after that edge.
REQ-031 The bench SHALL cover clr priority: clr=1 and wrt=1 to Rd=3 with data 0x1234 -> busy rises; after the sweep, entry 3 reads 0, and outputs read 0 during busy.
REQ-032 The bench SHALL cover ZERO_R0=1: write 0xFFFFFFFF to Rd=0 with Rs=0 in the same cycle -> Rs_out=0, and a later read of entry 0 returns 0.
REQ-033 The bench SHALL cover reset mid-sweep: assert rst at sweep cycle 30 -> outputs 0 immediately; after release, busy lasts a full 64 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//
// Parameterised register file with two registered read ports, one write port
// and a hardware clear sweep. While the sweep runs, one entry per cycle is
// zeroed in ascending order and the block reports busy. Writes and clear
// requests are ignored during that time, and both read outputs are held at 0.
// Reset starts the same sweep, so the array never needs a reset of its own.
//
// Parameters
//   DATA_W  - entry width in bits
//   ADDR_W  - address width; the array holds 2**ADDR_W entries
//   ZERO_R0 - when 1, entry 0 always reads as zero and ignores writes
//
// Ports
//   clk             - clock; all state changes on its rising edge
//   rst             - asynchronous active-high reset; starts a clear sweep
//   wrt             - write enable (honoured only when idle)
//   Rd              - write address
//   Rs, Rt          - read addresses
//   data_in         - write data
//   clr             - synchronous request to clear every entry
//   Rs_out, Rt_out  - registered read data with one cycle of latency
//   busy            - registered; high while the clear sweep runs
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    output logic [DATA_W-1:0] Rs_out,
    output logic [DATA_W-1:0] Rt_out,
    output logic              busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rs_out_q, rs_out_d;
    logic [DATA_W-1:0] rt_out_q, rt_out_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Read value for one port. Only an idle cycle without a clear request
    // returns data; a write to the same address is forwarded (write-first),
    // and entry 0 is forced to zero ahead of the forward when ZERO_R0 is set.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (state_q != IDLE || clr) return '0;
        if (ZERO_R0 && addr == '0)  return '0;
        if (wrt && Rd == addr)      return data_in;
        return mem_q[addr];
    endfunction

    // State register. Reset drops straight into a sweep from entry 0.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before the edge regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            rs_out_q <= '0;
            rt_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rs_out_q <= rs_out_d;
            rt_out_q <= rt_out_d;
        end
    end

    // NOTE: the array has no reset branch; the clear sweep zeroes it instead,
    // and the read outputs stay forced to 0 until that sweep has finished.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state logic. The counter wraps back to 0 on the final sweep edge.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Output / datapath logic: array write port, busy and the read registers.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = Rd;
        mem_wdata = data_in;
        busy_d    = (state_d == CLEAR);
        rs_out_d  = read_port(Rs);
        rt_out_d  = read_port(Rt);

        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wrt && !clr && !(ZERO_R0 && Rd == '0)) begin
            // A clear request in the same cycle wins over the write.
            mem_we = 1'b1;
        end
    end

    assign Rs_out = rs_out_q;
    assign Rt_out = rt_out_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//
// Self-checking bench for regfile_param with default sizes (32 x 64). Two
// instances share all inputs: one with ZERO_R0=0 and one with ZERO_R0=1, so
// the forced-zero entry 0 can be compared against normal behaviour.
// Idle traffic comes from a table of vectors; expected outputs are queued
// when each vector is driven and popped when the registered outputs appear.
// Clear sweeps and resets are exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int SWEEP_LEN = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrt;
    logic [AW-1:0] rd, rs, rt;
    logic [DW-1:0] din;
    logic          clr;
    logic [DW-1:0] rs_out, rt_out, z_rs_out, z_rt_out;
    logic          busy, z_busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic          wrt;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [DW-1:0] din;
        logic          clr;
        logic [DW-1:0] e_rs;
        logic [DW-1:0] e_rt;
        logic [DW-1:0] z_rs;
        logic [DW-1:0] z_rt;
        logic          e_busy;
    } vec_t;

    typedef struct {
        logic [DW-1:0] e_rs;
        logic [DW-1:0] e_rt;
        logic [DW-1:0] z_rs;
        logic [DW-1:0] z_rt;
        logic          e_busy;
        int            id;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[12];

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst), .wrt(wrt), .Rd(rd), .Rs(rs), .Rt(rt),
        .data_in(din), .clr(clr), .Rs_out(rs_out), .Rt_out(rt_out), .busy(busy)
    );

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst), .wrt(wrt), .Rd(rd), .Rs(rs), .Rt(rt),
        .data_in(din), .clr(clr), .Rs_out(z_rs_out), .Rt_out(z_rt_out), .busy(z_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] a_rd, input logic [AW-1:0] a_rs,
                                input logic [AW-1:0] a_rt, input logic [DW-1:0] d, input logic c,
                                input logic [DW-1:0] ers, input logic [DW-1:0] ert,
                                input logic [DW-1:0] zrs, input logic [DW-1:0] zrt, input logic eb);
        vec_t v;
        v.wrt = w;    v.rd = a_rd;  v.rs = a_rs;  v.rt = a_rt;  v.din = d;  v.clr = c;
        v.e_rs = ers; v.e_rt = ert; v.z_rs = zrs; v.z_rt = zrt; v.e_busy = eb;
        return v;
    endfunction

    task automatic idle_inputs();
        wrt = 1'b0; rd = '0; rs = '0; rt = '0; din = '0; clr = 1'b0;
    endtask

    // Drive one vector for one clock, queue its expectations, then compare.
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        exp_t got;
        @(negedge clk);
        wrt = v.wrt; rd = v.rd; rs = v.rs; rt = v.rt; din = v.din; clr = v.clr;
        e.e_rs = v.e_rs; e.e_rt = v.e_rt; e.z_rs = v.z_rs; e.z_rt = v.z_rt;
        e.e_busy = v.e_busy; e.id = id;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check($sformatf("v%0d Rs_out", got.id), rs_out, got.e_rs);
        check($sformatf("v%0d Rt_out", got.id), rt_out, got.e_rt);
        check($sformatf("v%0d z.Rs_out", got.id), z_rs_out, got.z_rs);
        check($sformatf("v%0d z.Rt_out", got.id), z_rt_out, got.z_rt);
        check($sformatf("v%0d busy", got.id), {31'b0, busy}, {31'b0, got.e_busy});
        idle_inputs();
    endtask

    // Count edges until busy falls; outputs must stay 0 meanwhile. At edge
    // poke_at (if nonzero) a write and a clear request are presented for one
    // cycle; both must be ignored.
    task automatic run_sweep(input string name, input int poke_at);
        int n = 0;
        bit out_bad = 1'b0;
        if (rs_out !== '0 || rt_out !== '0) out_bad = 1'b1;
        while (busy === 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1 && (rs_out !== '0 || rt_out !== '0 ||
                                  z_rs_out !== '0 || z_rt_out !== '0)) out_bad = 1'b1;
            if (n == poke_at) begin
                wrt = 1'b1; rd = 6'd5; din = 32'h0000_0077; clr = 1'b1; rs = 6'd5; rt = 6'd5;
            end else begin
                idle_inputs();
            end
        end
        idle_inputs();
        check({name, " busy length"}, n, SWEEP_LEN);
        check({name, " outputs zero while busy"}, {31'b0, out_bad}, 32'd0);
        check({name, " z.busy fallen"}, {31'b0, z_busy}, 32'd0);
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 6'd21, 6'd0,  6'd0,  32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tbl[1]  = mk(1'b0, 6'd0,  6'd21, 6'd0,  32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        tbl[2]  = mk(1'b1, 6'd7,  6'd7,  6'd7,  32'h5, 1'b0, 32'h5, 32'h5, 32'h5, 32'h5, 1'b0);
        tbl[3]  = mk(1'b0, 6'd0,  6'd7,  6'd21, 32'h0, 1'b0, 32'h5, 32'hDEAD_BEEF, 32'h5, 32'hDEAD_BEEF, 1'b0);
        tbl[4]  = mk(1'b1, 6'd63, 6'd21, 6'd21, 32'hA5A5_A5A5, 1'b0,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        tbl[5]  = mk(1'b0, 6'd0,  6'd63, 6'd7,  32'h0, 1'b0, 32'hA5A5_A5A5, 32'h5, 32'hA5A5_A5A5, 32'h5, 1'b0);
        tbl[6]  = mk(1'b1, 6'd7,  6'd21, 6'd7,  32'h1234_5678, 1'b0,
                     32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        tbl[7]  = mk(1'b0, 6'd0,  6'd7,  6'd63, 32'h0, 1'b0,
                     32'h1234_5678, 32'hA5A5_A5A5, 32'h1234_5678, 32'hA5A5_A5A5, 1'b0);
        tbl[8]  = mk(1'b0, 6'd0,  6'd21, 6'd63, 32'h0, 1'b0,
                     32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 1'b0);
        tbl[9]  = mk(1'b1, 6'd0,  6'd0,  6'd21, 32'hFFFF_FFFF, 1'b0,
                     32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);
        tbl[10] = mk(1'b0, 6'd0,  6'd0,  6'd0,  32'h0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        tbl[11] = mk(1'b1, 6'd3,  6'd3,  6'd0,  32'hCAFE_F00D, 1'b0,
                     32'hCAFE_F00D, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0, 1'b0);

        // Reset state, held across a few edges.
        rst = 1'b1;
        idle_inputs();
        #3;
        check("reset busy", {31'b0, busy}, 32'd1);
        check("reset Rs_out", rs_out, 32'h0);
        check("reset Rt_out", rt_out, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("reset sweep", 0);

        // Every entry reads zero after the reset sweep.
        for (int i = 0; i < SWEEP_LEN; i++) begin
            apply(mk(1'b0, 6'd0, 6'(i), 6'(SWEEP_LEN - 1 - i), 32'h0, 1'b0,
                     32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 100 + i);
        end

        // Idle write/read/bypass/ZERO_R0 table.
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i], i);
        end

        // Clear beats a simultaneous write; a write and clr during busy are ignored.
        apply(mk(1'b1, 6'd3, 6'd3, 6'd3, 32'h0000_1234, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1), 200);
        run_sweep("clr sweep", 10);
        apply(mk(1'b0, 6'd0, 6'd3,  6'd5,  32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 201);
        apply(mk(1'b0, 6'd0, 6'd63, 6'd21, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 202);

        // Asynchronous reset from idle with nonzero outputs.
        apply(mk(1'b1, 6'd9, 6'd9, 6'd9, 32'h9999_0000, 1'b0,
                 32'h9999_0000, 32'h9999_0000, 32'h9999_0000, 32'h9999_0000, 1'b0), 300);
        #2 rst = 1'b1;
        #1;
        check("async rst Rs_out", rs_out, 32'h0);
        check("async rst Rt_out", rt_out, 32'h0);
        check("async rst busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("idle rst sweep", 0);
        apply(mk(1'b0, 6'd0, 6'd9, 6'd9, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 301);

        // Reset at sweep cycle 30 restarts the sweep from entry 0.
        apply(mk(1'b1, 6'd9, 6'd9, 6'd9, 32'h0000_ABCD, 1'b0,
                 32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_ABCD, 32'h0000_ABCD, 1'b0), 400);
        apply(mk(1'b0, 6'd0, 6'd9, 6'd9, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1), 401);
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-sweep rst Rs_out", rs_out, 32'h0);
        check("mid-sweep rst busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("restarted sweep", 0);
        apply(mk(1'b0, 6'd0, 6'd9, 6'd63, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0), 402);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
